sram_rr_arbiter: RTL

- Shares one single-port 16b x 2048 SRAM macro (active-low CEN/WEN, registered read address, Q valid the cycle after the read edge) between three requesters:
  - one write port, fed by the output FIFO drain;
  - two read ports, rd0 (L0 loader) and rd1 (psum readback).
- Round-robin arbitration, with at most one SRAM access per cycle.
- Read data is returned with a per-port valid strobe one cycle after the grant.
- Sits between the core datapath and the SRAM instance.

---
 rtl/sram_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a write port and two read ports.
// Optional performance counters are enabled by defining SRAM_RR_ARBITER_PERF_EN.
module sram_rr_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
`ifdef SRAM_RR_ARBITER_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_wr_cnt,
    output logic [CNT_W-1:0]  perf_rd_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [1:0] ptr_q, ptr_d;
    logic       rd0_valid_q, rd1_valid_q;
    logic [2:0] req, gnt;

    // Bit order everywhere: [0] = write, [1] = rd0, [2] = rd1.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd2: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    assign req     = {rd1_req, rd0_req, wr_req};
    assign gnt     = reset ? 3'b000 : rr_pick(ptr_q, req);
    assign wr_gnt  = gnt[0];
    assign rd0_gnt = gnt[1];
    assign rd1_gnt = gnt[2];

    always_comb begin
        ptr_d = ptr_q;
        case (gnt)
            3'b001:  ptr_d = 2'd1;
            3'b010:  ptr_d = 2'd2;
            3'b100:  ptr_d = 2'd0;
            default: ptr_d = ptr_q;
        endcase
    end

    always_comb begin
        sram_cen = ~|gnt;
        sram_wen = ~gnt[0];
        sram_a   = '0;
        sram_d   = '0;
        if (gnt[0]) begin
            sram_a = wr_addr;
            sram_d = wr_data;
        end else if (gnt[1]) begin
            sram_a = rd0_addr;
        end else if (gnt[2]) begin
            sram_a = rd1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= 2'd0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rd0_valid_q <= gnt[1];
            rd1_valid_q <= gnt[2];
        end
    end

    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
    assign rd_data   = sram_q;

`ifdef SRAM_RR_ARBITER_PERF_EN
    logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q, stall_cnt_q;
    logic             stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    // A stall is any requester asserting req without being granted this cycle.
    assign stall = |(req & ~gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_cnt_q    <= sat_inc(wr_cnt_q, gnt[0]);
            rd_cnt_q    <= sat_inc(rd_cnt_q, gnt[1] | gnt[2]);
            stall_cnt_q <= sat_inc(stall_cnt_q, stall);
        end
    end

    assign perf_wr_cnt    = wr_cnt_q;
    assign perf_rd_cnt    = rd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
